// File: rtl/branch_resolve.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | branch_resolve: MB-stage branch/trap resolution and trap CSR owner     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module branch_resolve #(
  parameter logic [31:0] MTVEC_RESET = 32'h00000010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_flush,
  input  logic        ex_mb__valid,
  input  logic [31:0] ex_mb__pc,
  input  logic        ex_mb__predict_taken,
  input  logic        ex_mb__is_branch,
  input  logic        ex_mb__is_jump,
  input  logic        ex_mb__cond,
  input  logic [31:0] ex_mb__target,
  input  logic        ex_mb__ins_misalign,
  input  logic        ex_mb__ecall,
  input  logic        ex_mb__ebreak,
  input  logic        ex_mb__mret,
  input  logic        ex_mb__csr_we,
  input  logic [11:0] ex_mb__csr_addr,
  input  logic [31:0] ex_mb__csr_wdata,
  output logic [31:0] mb_if__jump_target,
  output logic        mb_if__branch_taken,
  output logic        mb_if__trap_taken,
  output logic        mb_if__predict_taken,
  output logic [31:0] mb_if__pc_4,
  output logic [31:0] mb_wb__csr_rdata
);

  localparam logic [11:0] C_CSR_MTVEC    = 12'h305;
  localparam logic [11:0] C_CSR_MEPC     = 12'h341;
  localparam logic [11:0] C_CSR_MCAUSE   = 12'h342;
  localparam logic [31:0] C_CAUSE_MISAL  = 32'd0;
  localparam logic [31:0] C_CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] C_CAUSE_ECALL  = 32'd11;

  logic        mb_valid_q;
  logic [31:0] pc_q;
  logic        predict_q;
  logic        is_branch_q;
  logic        is_jump_q;
  logic        cond_q;
  logic [31:0] target_q;
  logic        misalign_q;
  logic        ecall_q;
  logic        ebreak_q;
  logic        mret_q;
  logic        csr_we_q;
  logic [11:0] csr_addr_q;
  logic [31:0] csr_wdata_q;

  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic        w_trap;
  logic [31:0] w_cause;
  logic        w_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      mb_valid_q  <= 1'b0;
      pc_q        <= 32'd0;
      predict_q   <= 1'b0;
      is_branch_q <= 1'b0;
      is_jump_q   <= 1'b0;
      cond_q      <= 1'b0;
      target_q    <= 32'd0;
      misalign_q  <= 1'b0;
      ecall_q     <= 1'b0;
      ebreak_q    <= 1'b0;
      mret_q      <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= 12'd0;
      csr_wdata_q <= 32'd0;
    end else begin
      mb_valid_q  <= ex_mb__valid;
      pc_q        <= ex_mb__pc;
      predict_q   <= ex_mb__predict_taken;
      is_branch_q <= ex_mb__is_branch;
      is_jump_q   <= ex_mb__is_jump;
      cond_q      <= ex_mb__cond;
      target_q    <= ex_mb__target;
      misalign_q  <= ex_mb__ins_misalign;
      ecall_q     <= ex_mb__ecall;
      ebreak_q    <= ex_mb__ebreak;
      mret_q      <= ex_mb__mret;
      csr_we_q    <= ex_mb__csr_we;
      csr_addr_q  <= ex_mb__csr_addr;
      csr_wdata_q <= ex_mb__csr_wdata;
    end
  end

  always_comb begin
    w_trap   = mb_valid_q & (misalign_q | ebreak_q | ecall_q);
    w_commit = mb_valid_q & ~pipe_flush;
    if (misalign_q)    w_cause = C_CAUSE_MISAL;
    else if (ebreak_q) w_cause = C_CAUSE_EBREAK;
    else               w_cause = C_CAUSE_ECALL;
  end

  always_comb begin
    mb_if__jump_target   = 32'd0;
    mb_if__branch_taken  = 1'b0;
    mb_if__trap_taken    = 1'b0;
    mb_if__predict_taken = 1'b0;
    mb_if__pc_4          = 32'd0;
    mb_wb__csr_rdata     = 32'd0;
    if (mb_valid_q) begin
      mb_if__predict_taken = predict_q;
      mb_if__pc_4          = pc_q + 32'd4;
      mb_if__branch_taken  = ~w_trap & (is_jump_q | (is_branch_q & cond_q));
      mb_if__trap_taken    = w_trap | mret_q;
      // Trap outranks mret when both decode on the same instruction.
      if (w_trap)      mb_if__jump_target = {mtvec_q[31:2], 2'b00};
      else if (mret_q) mb_if__jump_target = mepc_q;
      else             mb_if__jump_target = target_q;
      case (csr_addr_q)
        C_CSR_MTVEC:  mb_wb__csr_rdata = mtvec_q;
        C_CSR_MEPC:   mb_wb__csr_rdata = mepc_q;
        C_CSR_MCAUSE: mb_wb__csr_rdata = mcause_q;
        default:      mb_wb__csr_rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (w_commit) begin
      // A trapping instruction drops its own CSR write.
      if (w_trap) begin
        mepc_d   = pc_q;
        mcause_d = w_cause;
      end else if (csr_we_q) begin
        case (csr_addr_q)
          C_CSR_MTVEC:  mtvec_d  = {csr_wdata_q[31:2], 2'b00};
          C_CSR_MEPC:   mepc_d   = {csr_wdata_q[31:2], 2'b00};
          C_CSR_MCAUSE: mcause_d = csr_wdata_q;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
    end else begin
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_branch_resolve: directed scoreboard bench for branch_resolve        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_branch_resolve;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        pred, br, jmp, cond;
    logic [31:0] tgt;
    logic        mis, ec, eb, mr, we;
    logic [11:0] addr;
    logic [31:0] wd;
  } instr_t;

  typedef struct {
    logic [31:0] jt;
    logic        bt, tt, pt;
    logic [31:0] pc4, rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_flush = 1'b0;
  logic        ex_valid = 1'b0, ex_pred = 1'b0, ex_br = 1'b0, ex_jmp = 1'b0, ex_cond = 1'b0;
  logic [31:0] ex_pc = 32'd0, ex_tgt = 32'd0, ex_wd = 32'd0;
  logic        ex_mis = 1'b0, ex_ec = 1'b0, ex_eb = 1'b0, ex_mr = 1'b0, ex_we = 1'b0;
  logic [11:0] ex_addr = 12'd0;
  logic [31:0] jt, pc4, rdata;
  logic        bt, tt, pt;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t        sb[$];
  logic [31:0] m_mtvec, m_mepc, m_mcause;

  always #5 clk = ~clk;

  branch_resolve #(.MTVEC_RESET(32'h00000010)) dut (
    .clk(clk), .rst(rst), .pipe_flush(pipe_flush),
    .ex_mb__valid(ex_valid), .ex_mb__pc(ex_pc), .ex_mb__predict_taken(ex_pred),
    .ex_mb__is_branch(ex_br), .ex_mb__is_jump(ex_jmp), .ex_mb__cond(ex_cond),
    .ex_mb__target(ex_tgt), .ex_mb__ins_misalign(ex_mis), .ex_mb__ecall(ex_ec),
    .ex_mb__ebreak(ex_eb), .ex_mb__mret(ex_mr), .ex_mb__csr_we(ex_we),
    .ex_mb__csr_addr(ex_addr), .ex_mb__csr_wdata(ex_wd),
    .mb_if__jump_target(jt), .mb_if__branch_taken(bt), .mb_if__trap_taken(tt),
    .mb_if__predict_taken(pt), .mb_if__pc_4(pc4), .mb_wb__csr_rdata(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic instr_t nop();
    instr_t s;
    s.v = 1'b1; s.pc = 32'h0; s.pred = 1'b0; s.br = 1'b0; s.jmp = 1'b0; s.cond = 1'b0;
    s.tgt = 32'h0; s.mis = 1'b0; s.ec = 1'b0; s.eb = 1'b0; s.mr = 1'b0; s.we = 1'b0;
    s.addr = 12'h0; s.wd = 32'h0;
    return s;
  endfunction

  function automatic logic [31:0] csr_model(input logic [11:0] a);
    case (a)
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t predict(input instr_t s);
    exp_t e;
    logic trap;
    e.jt = 0; e.bt = 0; e.tt = 0; e.pt = 0; e.pc4 = 0; e.rdata = 0;
    if (s.v) begin
      trap    = s.mis | s.eb | s.ec;
      e.pt    = s.pred;
      e.pc4   = s.pc + 32'd4;
      e.tt    = trap | s.mr;
      e.bt    = trap ? 1'b0 : (s.jmp | (s.br & s.cond));
      e.jt    = trap ? {m_mtvec[31:2], 2'b00} : (s.mr ? m_mepc : s.tgt);
      e.rdata = csr_model(s.addr);
    end
    return e;
  endfunction

  task automatic compare_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".jump_target"}, jt, e.jt);
    chk({tag, ".branch_taken"}, {31'd0, bt}, {31'd0, e.bt});
    chk({tag, ".trap_taken"}, {31'd0, tt}, {31'd0, e.tt});
    chk({tag, ".predict_taken"}, {31'd0, pt}, {31'd0, e.pt});
    chk({tag, ".pc_4"}, pc4, e.pc4);
    chk({tag, ".csr_rdata"}, rdata, e.rdata);
  endtask

  // One instruction through MB; flush applies during its MB cycle.
  task automatic send(input string tag, input instr_t s, input logic flush);
    sb.push_back(predict(s));
    @(negedge clk);
    ex_valid = s.v; ex_pc = s.pc; ex_pred = s.pred; ex_br = s.br; ex_jmp = s.jmp;
    ex_cond = s.cond; ex_tgt = s.tgt; ex_mis = s.mis; ex_ec = s.ec; ex_eb = s.eb;
    ex_mr = s.mr; ex_we = s.we; ex_addr = s.addr; ex_wd = s.wd;
    @(posedge clk);
    #1;
    compare_head(tag);
    pipe_flush = flush;
    if (s.v && !flush) begin
      if (s.mis | s.eb | s.ec) begin
        m_mepc   = s.pc;
        m_mcause = s.mis ? 32'd0 : (s.eb ? 32'd3 : 32'd11);
      end else if (s.we) begin
        case (s.addr)
          12'h305: m_mtvec  = {s.wd[31:2], 2'b00};
          12'h341: m_mepc   = {s.wd[31:2], 2'b00};
          12'h342: m_mcause = s.wd;
          default: ;
        endcase
      end
    end
  endtask

  task automatic rd_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    instr_t s;
    s = nop(); s.pc = 32'h900; s.addr = a;
    send(tag, s, 1'b0);
    chk({tag, ".direct"}, rdata, exp);
  endtask

  initial begin
    instr_t s;
    m_mtvec = 32'h10; m_mepc = 32'h0; m_mcause = 32'h0;

    // Reset state
    rst = 1'b1;
    s = nop(); s.v = 1'b0;
    sb.push_back(predict(s));
    @(posedge clk); #1;
    compare_head("reset");
    @(negedge clk); rst = 1'b0;

    s = nop(); s.pc = 32'h100; s.br = 1; s.cond = 1; s.tgt = 32'h80;
    send("taken_branch", s, 1'b0);

    s = nop(); s.pc = 32'h104; s.br = 1; s.cond = 0; s.tgt = 32'h80; s.pred = 1;
    send("not_taken_pred", s, 1'b0);

    s = nop(); s.pc = 32'h200; s.ec = 1; s.tgt = 32'h55;
    send("ecall", s, 1'b0);
    chk("ecall.jt_direct", jt, 32'h10);

    s = nop(); s.pc = 32'h204; s.addr = 12'h341;
    send("post_ecall_squashed", s, 1'b1);
    chk("ecall.mepc", rdata, 32'h200);
    rd_csr("ecall.mcause", 12'h342, 32'd11);

    s = nop(); s.pc = 32'h300; s.mr = 1;
    send("mret", s, 1'b0);
    chk("mret.jt_direct", jt, 32'h200);

    s = nop(); s.pc = 32'h400; s.ec = 1;
    send("ecall_squashed", s, 1'b1);
    s = nop(); s.pc = 32'h404; s.we = 1; s.addr = 12'h305; s.wd = 32'h123;
    send("mtvec_wr_squashed", s, 1'b1);
    rd_csr("squash.mepc", 12'h341, 32'h200);
    rd_csr("squash.mcause", 12'h342, 32'd11);
    rd_csr("squash.mtvec", 12'h305, 32'h10);

    s = nop(); s.pc = 32'h500; s.mis = 1; s.eb = 1; s.jmp = 1; s.pred = 1;
    s.we = 1; s.addr = 12'h341; s.wd = 32'hABC0; s.tgt = 32'h777;
    send("priority", s, 1'b0);
    rd_csr("priority.mepc", 12'h341, 32'h500);
    rd_csr("priority.mcause", 12'h342, 32'd0);

    s = nop(); s.pc = 32'h504; s.we = 1; s.addr = 12'h305; s.wd = 32'h1003;
    send("mtvec_wr", s, 1'b0);
    rd_csr("mtvec_rb", 12'h305, 32'h1000);

    s = nop(); s.pc = 32'h600; s.eb = 1;
    send("ebreak", s, 1'b0);
    chk("ebreak.jt_direct", jt, 32'h1000);
    rd_csr("ebreak.mcause", 12'h342, 32'd3);

    s = nop(); s.pc = 32'hFFFF_FFFC; s.jmp = 1; s.tgt = 32'h40;
    send("pc_wrap", s, 1'b0);
    chk("pc_wrap.direct", pc4, 32'h0);

    s = nop(); s.pc = 32'h700; s.ec = 1; s.mr = 1;
    send("trap_and_mret", s, 1'b0);

    s = nop(); s.pc = 32'h704; s.we = 1; s.addr = 12'h341; s.wd = 32'h2003;
    send("mepc_wr", s, 1'b0);
    s = nop(); s.pc = 32'h708; s.mr = 1;
    send("mret_after_wr", s, 1'b0);
    chk("mret_after_wr.direct", jt, 32'h2000);

    s = nop(); s.v = 1'b0; s.pc = 32'h123; s.jmp = 1; s.ec = 1; s.pred = 1; s.addr = 12'h305;
    send("idle", s, 1'b0);

    s = nop(); s.pc = 32'h800; s.ec = 1;
    send("trap_before_rst", s, 1'b0);
    @(negedge clk);
    rst = 1'b1; ex_valid = 1'b0;
    m_mtvec = 32'h10; m_mepc = 32'h0; m_mcause = 32'h0;
    s = nop(); s.v = 1'b0;
    sb.push_back(predict(s));
    @(posedge clk); #1;
    compare_head("mid_rst");
    @(negedge clk); rst = 1'b0;
    rd_csr("rst.mepc", 12'h341, 32'h0);
    rd_csr("rst.mcause", 12'h342, 32'h0);
    rd_csr("rst.mtvec", 12'h305, 32'h10);

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
